// File: rtl/acpo_readout_ctrl_if.sv
// Valid/ready output stream of the activation/pooling readout sequencer.
// The sequencer drives the master side; the next-layer loader uses the slave side.
interface acpo_readout_ctrl_if #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 10
);
    logic                     out_valid_o;
    logic                     out_ready_i;
    logic [DATA_WIDTH-1:0]    out_data_o;
    logic [ADDRESS_WIDTH-1:0] out_addr_o;
    logic                     out_last_o;

    modport master (
        output out_valid_o, out_data_o, out_addr_o, out_last_o,
        input  out_ready_i
    );

    modport slave (
        input  out_valid_o, out_data_o, out_addr_o, out_last_o,
        output out_ready_i
    );
endinterface

// File: rtl/acpo_readout_ctrl.sv
// Read-side sequencer for the SA data/address and FC output buffers: walks the
// selected buffer, absorbs the one-cycle BRAM latency and streams through a 3-deep skid FIFO.
module acpo_readout_ctrl #(
    parameter int SRAM_DEPTH    = 1024,
    parameter int BAND_WIDTH    = 16,
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 10,
    localparam int LW = $clog2(SRAM_DEPTH),
    localparam int BW = $clog2(BAND_WIDTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_i,
    input  logic                     mode_i,
    input  logic [BW:0]              bank_cnt_i,
    input  logic [LW:0]              lane_cnt_i,
    input  logic [LW:0]              fc_cnt_i,
    output logic                     enb_d_sa,
    output logic                     enb_a,
    output logic [LW+BW-1:0]         addrb_d_sa,
    output logic [LW+BW-1:0]         addrb_a,
    output logic                     enb_d_fc,
    output logic [LW-1:0]            addrb_d_fc,
    input  logic [DATA_WIDTH-1:0]    dob_d_sa,
    input  logic [ADDRESS_WIDTH-1:0] dob_a,
    input  logic [DATA_WIDTH-1:0]    dob_d_fc,
    acpo_readout_ctrl_if.master      out_if,
    output logic                     busy_o,
    output logic                     done_o
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0]    data;
        logic [ADDRESS_WIDTH-1:0] addr;
        logic                     last;
    } elem_t;

    state_t          state_q, state_d;
    logic            mode_q, mode_d;
    logic [BW-1:0]   bank_last_q, bank_last_d;
    logic [LW-1:0]   lane_last_q, lane_last_d;
    logic [BW-1:0]   bank_q, bank_d;
    logic [LW-1:0]   entry_q, entry_d;
    logic            inflight_q, inflight_d;
    logic            infl_last_q, infl_last_d;
    logic [LW-1:0]   infl_idx_q, infl_idx_d;
    elem_t           mem_q [3];
    elem_t           mem_d [3];
    logic [1:0]      wr_q, wr_d;
    logic [1:0]      rd_q, rd_d;
    logic [1:0]      cnt_q, cnt_d;

    logic [BW:0]     bank_sat;
    logic [LW:0]     lane_sat;
    logic [LW:0]     fc_sat;
    logic            zero_run;
    logic            issue;
    logic            final_rd;
    logic            valid;
    logic            pop;
    elem_t           head;
    elem_t           wdata;

    assign bank_sat = (bank_cnt_i > (BW+1)'(BAND_WIDTH)) ? (BW+1)'(BAND_WIDTH) : bank_cnt_i;
    assign lane_sat = (lane_cnt_i > (LW+1)'(SRAM_DEPTH)) ? (LW+1)'(SRAM_DEPTH) : lane_cnt_i;
    assign fc_sat   = (fc_cnt_i   > (LW+1)'(SRAM_DEPTH)) ? (LW+1)'(SRAM_DEPTH) : fc_cnt_i;
    assign zero_run = mode_i ? (fc_sat == '0) : ((bank_sat == '0) || (lane_sat == '0));

    // Issue gating uses registered occupancy only, so out_ready_i never reaches the enables.
    assign issue    = (state_q == ISSUE) && (({1'b0, cnt_q} + {2'b00, inflight_q}) < 3'd3);
    // FC runs keep bank_q at 0, so the entry compare alone ends them.
    assign final_rd = (entry_q == lane_last_q) && (mode_q || (bank_q == bank_last_q));

    assign valid = (cnt_q != 2'd0);
    assign pop   = valid && out_if.out_ready_i;
    assign head  = mem_q[rd_q];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            mode_q      <= 1'b0;
            bank_last_q <= '0;
            lane_last_q <= '0;
            bank_q      <= '0;
            entry_q     <= '0;
            inflight_q  <= 1'b0;
            infl_last_q <= 1'b0;
            infl_idx_q  <= '0;
            wr_q        <= '0;
            rd_q        <= '0;
            cnt_q       <= '0;
            for (int unsigned i = 0; i < 3; i++) mem_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            bank_last_q <= bank_last_d;
            lane_last_q <= lane_last_d;
            bank_q      <= bank_d;
            entry_q     <= entry_d;
            inflight_q  <= inflight_d;
            infl_last_q <= infl_last_d;
            infl_idx_q  <= infl_idx_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            cnt_q       <= cnt_d;
            mem_q       <= mem_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = zero_run ? DONE : ISSUE;
            ISSUE:   if (issue && final_rd) state_d = DRAIN;
            DRAIN:   if (pop && head.last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mode_d      = mode_q;
        bank_last_d = bank_last_q;
        lane_last_d = lane_last_q;
        bank_d      = bank_q;
        entry_d     = entry_q;
        mem_d       = mem_q;
        wr_d        = wr_q;
        rd_d        = rd_q;
        cnt_d       = cnt_q;

        if ((state_q == IDLE) && start_i) begin
            mode_d      = mode_i;
            bank_last_d = BW'(bank_sat - (BW+1)'(1));
            lane_last_d = LW'((mode_i ? fc_sat : lane_sat) - (LW+1)'(1));
            bank_d      = '0;
            entry_d     = '0;
        end else if (issue && !final_rd) begin
            if (!mode_q && (entry_q == lane_last_q)) begin
                entry_d = '0;
                bank_d  = bank_q + BW'(1);
            end else begin
                entry_d = entry_q + LW'(1);
            end
        end

        inflight_d  = issue;
        infl_last_d = issue && final_rd;
        infl_idx_d  = entry_q;

        wdata.data = mode_q ? dob_d_fc : dob_d_sa;
        wdata.addr = mode_q ? ADDRESS_WIDTH'(infl_idx_q) : dob_a;
        wdata.last = infl_last_q;

        if (inflight_q) begin
            mem_d[wr_q] = wdata;
            wr_d        = (wr_q == 2'd2) ? 2'd0 : wr_q + 2'd1;
        end
        if (pop) rd_d = (rd_q == 2'd2) ? 2'd0 : rd_q + 2'd1;
        case ({inflight_q, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_comb begin
        busy_o             = (state_q == ISSUE) || (state_q == DRAIN);
        done_o             = (state_q == DONE);
        enb_d_sa           = issue && !mode_q;
        enb_a              = enb_d_sa;
        addrb_d_sa         = enb_d_sa ? {bank_q, entry_q} : '0;
        addrb_a            = addrb_d_sa;
        enb_d_fc           = issue && mode_q;
        addrb_d_fc         = enb_d_fc ? entry_q : '0;
        out_if.out_valid_o = valid;
        out_if.out_data_o  = valid ? head.data : '0;
        out_if.out_addr_o  = valid ? head.addr : '0;
        out_if.out_last_o  = valid && head.last;
    end

endmodule
